key_remap_ctrl: RTL and testbench
=================================

KEY_REMAP_CTRL -- requirements
Module: key_remap_ctrl

Interface
REQ-001 The block SHALL have parameter NOTE_KEY_BITS, default `NOTE_KEY_BITS (7), meaning the number of note/key lines.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the stable cycles required before a key level is accepted.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 500_000_000, meaning the idle cycles allowed in a selection state before abort.
REQ-004 The block SHALL have port: clk, input, 1, system clock.
REQ-005 The block SHALL have port: rst, input, 1, reset. One clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port: start, input, 1, level/pulse request to begin one remap transaction.
REQ-007 The block SHALL have port: cancel, input, 1, abort of the current transaction.
REQ-008 The block SHALL have port: keys, input, NOTE_KEY_BITS, raw physical key levels (1 = pressed).
REQ-009 The block SHALL have port: ram_rw, output, 1, write strobe to the key-map RAM.
REQ-010 The block SHALL have port: ram_addr, output, NOTE_KEY_BITS, one-hot note slot being written.
REQ-011 The block SHALL have port: ram_data, output, NOTE_KEY_BITS, one-hot physical key bound to that note.
REQ-012 The block SHALL have port: busy, output, 1, high while not IDLE.
REQ-013 The block SHALL have port: done, output, 1, one-cycle pulse after a successful write.
REQ-014 The block SHALL have port: err, output, 1, one-cycle pulse on multi-key press or timeout.

Function
REQ-015 Keys SHALL pass through the debouncer; the FSM uses only the debounced vector db and its previous-cycle copy db_q.
REQ-016 A "press" SHALL be db_q == 0 and popcount(db) == 1; a "release" SHALL be db == 0.
REQ-017 States SHALL be IDLE, SEL_NOTE, WAIT_REL, SEL_KEY, WRITE, FINISH.
REQ-018 IDLE -> SEL_NOTE SHALL occur on start == 1; start is ignored in all other states.
REQ-019 SEL_NOTE SHALL latch db into note_reg on a press and go to WAIT_REL.
REQ-020 WAIT_REL SHALL go to SEL_KEY on release.
REQ-021 SEL_KEY SHALL latch db into key_reg on a press and go to WRITE.
REQ-022 WRITE SHALL last exactly one cycle with ram_rw = 1, ram_addr = note_reg, ram_data = key_reg, then go to FINISH.
REQ-023 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-024 Outside WRITE, ram_rw SHALL be 0 and ram_addr/ram_data SHALL be 0.
REQ-025 In SEL_NOTE or SEL_KEY, db_q == 0 with popcount(db) >= 2 SHALL pulse err once and keep the state, with no latch.
REQ-026 cancel SHALL return any non-IDLE state to IDLE next cycle with no write; cancel in WRITE SHALL suppress ram_rw; cancel takes priority over every other transition.
REQ-027 Write latency SHALL be 2 cycles from the accepted key press (latch cycle, then WRITE).

Reset
REQ-028 rst SHALL force IDLE, note_reg = key_reg = 0, db = db_q = 0, debounce and timeout counters = 0, and all outputs = 0 on the next clk edge, including mid-transaction; no partial write SHALL occur.

Configuration
REQ-029 With REMAP_TIMEOUT_EN defined, a counter SHALL run in SEL_NOTE, WAIT_REL and SEL_KEY and clear on every state change; reaching TIMEOUT_CYCLES-1 SHALL pulse err and return to IDLE.
REQ-030 Without REMAP_TIMEOUT_EN, there SHALL be no timeout counter, and the FSM SHALL wait indefinitely.

Structure
REQ-031 NOTE_KEY_BITS and the FSM state encoding (3-bit localparams) SHALL reside in the shared Constants.vh.
REQ-032 The block SHALL contain one sub-module, key_debounce (per-bit counter, output updates only after DEBOUNCE_CYCLES consecutive equal samples).

Verification
Run the bench with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=100.
REQ-033 Scenario: start, press key 2 (7'b0000100), release, press key 5 (7'b0100000) -> one cycle with ram_rw=1, ram_addr=7'b0000100, ram_data=7'b0100000, then done=1 next cycle, busy low after.
REQ-034 Scenario: in SEL_NOTE, press 7'b0000011 -> err pulse, still SEL_NOTE; then release, press 7'b0001000 -> note_reg=7'b0001000.
REQ-035 Scenario: a bounce of 3 cycles high, 1 low on key 0 -> no press accepted; 4 stable cycles -> accepted.
REQ-036 Scenario: assert cancel in SEL_KEY, and separately in WRITE -> ram_rw never asserted, IDLE next cycle, no done.
REQ-037 Scenario: assert rst in WAIT_REL -> all outputs 0 next cycle; a new start then works normally.
REQ-038 Scenario: with REMAP_TIMEOUT_EN, start and no keys for 100 cycles -> err pulse, IDLE; without the macro -> still busy after 1000 cycles.

Source files
------------

// File: rtl/key_remap_ctrl_pkg.sv
// key_remap_ctrl_pkg: shared note/key width and remap FSM state encoding.
package key_remap_ctrl_pkg;
   localparam int NOTE_KEY_BITS = 7;
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEL_NOTE = 3'd1,
      WAIT_REL = 3'd2,
      SEL_KEY  = 3'd3,
      WRITE    = 3'd4,
      FINISH   = 3'd5
   } state_t;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: per-bit debouncer; a bit follows raw only after CYCLES consecutive differing samples.
module key_debounce #(
   parameter int W      = key_remap_ctrl_pkg::NOTE_KEY_BITS,
   parameter int CYCLES = 1_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw,
   output logic [W-1:0] db
);
   import key_remap_ctrl_pkg::*;
   localparam int CW = $clog2(CYCLES + 1);
   for (genvar b = 0; b < W; b++) begin : g_bit
      logic [CW-1:0] cnt;
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt   <= '0;
            db[b] <= 1'b0;
         end else if (raw[b] == db[b]) begin
            cnt <= '0;
         end else if (cnt == CW'(CYCLES - 1)) begin
            cnt   <= '0;
            db[b] <= raw[b];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/key_remap_ctrl.sv
// key_remap_ctrl: binds a selected note slot to a physical key and writes it to the key-map RAM.
// Optional REMAP_TIMEOUT_EN aborts a selection that sits idle for TIMEOUT_CYCLES.
module key_remap_ctrl #(
   parameter int NOTE_KEY_BITS   = key_remap_ctrl_pkg::NOTE_KEY_BITS,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TIMEOUT_CYCLES  = 500_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     cancel,
   input  logic [NOTE_KEY_BITS-1:0] keys,
   output logic                     ram_rw,
   output logic [NOTE_KEY_BITS-1:0] ram_addr,
   output logic [NOTE_KEY_BITS-1:0] ram_data,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);
   import key_remap_ctrl_pkg::*;
   state_t state, state_nx;
   logic [NOTE_KEY_BITS-1:0] db, db_q, note_reg, key_reg;
   logic press, multi, rel, to_hit;
   key_debounce #(.W(NOTE_KEY_BITS), .CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk (clk),
      .rst (rst),
      .raw (keys),
      .db  (db)
   );
   assign press = db_q == '0 && $countones(db) == 1;
   assign multi = db_q == '0 && $countones(db) > 1;
   assign rel   = db == '0;
   assign busy  = state != IDLE;
`ifdef REMAP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;
   logic          sel;
   assign sel    = state inside {SEL_NOTE, WAIT_REL, SEL_KEY};
   assign to_hit = sel && to_cnt == TW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk) begin
      if (rst || !sel || state_nx != state)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end
`else
   assign to_hit = 1'b0;
`endif
   // cancel outranks timeout, which outranks any key activity
   always_comb begin
      state_nx = state;
      ram_rw   = 1'b0;
      ram_addr = '0;
      ram_data = '0;
      done     = 1'b0;
      err      = 1'b0;
      if (state != IDLE && cancel) begin
         state_nx = IDLE;
      end else if (to_hit) begin
         state_nx = IDLE;
         err      = 1'b1;
      end else begin
         case (state)
            IDLE:     state_nx = start ? SEL_NOTE : IDLE;
            SEL_NOTE: begin
               state_nx = press ? WAIT_REL : SEL_NOTE;
               err      = multi;
            end
            WAIT_REL: state_nx = rel ? SEL_KEY : WAIT_REL;
            SEL_KEY:  begin
               state_nx = press ? WRITE : SEL_KEY;
               err      = multi;
            end
            WRITE:    begin
               ram_rw   = 1'b1;
               ram_addr = note_reg;
               ram_data = key_reg;
               state_nx = FINISH;
            end
            FINISH:   begin
               done     = 1'b1;
               state_nx = IDLE;
            end
            default:  state_nx = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         db_q     <= '0;
         note_reg <= '0;
         key_reg  <= '0;
      end else begin
         state <= state_nx;
         db_q  <= db;
         if (state == SEL_NOTE && state_nx == WAIT_REL)
            note_reg <= db;
         if (state == SEL_KEY && state_nx == WRITE)
            key_reg <= db;
      end
   end
endmodule

// File: tb/tb_key_remap_ctrl.sv
// tb_key_remap_ctrl: randomized and directed checks of key_remap_ctrl against a transaction-level model.
module tb_key_remap_ctrl;
   localparam int W  = 7;
   localparam int DB = 4;
   localparam int TO = 100;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, cancel = 1'b0;
   logic [W-1:0] keys = '0;
   logic ram_rw, busy, done, err;
   logic [W-1:0] ram_addr, ram_data;
   int errors = 0, checks = 0;
   int n_wr = 0, n_done = 0, n_err = 0;
   logic [W-1:0] wr_addr[$], wr_data[$];
   logic [W-1:0] exp_addr[$], exp_data[$];

   key_remap_ctrl #(.NOTE_KEY_BITS(W), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .cancel   (cancel),
      .keys     (keys),
      .ram_rw   (ram_rw),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ram_rw) begin
         wr_addr.push_back(ram_addr);
         wr_data.push_back(ram_data);
         n_wr++;
      end
      if (done) n_done++;
      if (err) n_err++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hold(input logic [W-1:0] v, input int n);
      keys = v;
      cyc(n);
   endtask

   task automatic begin_txn();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   // press the note long enough to latch, then release into key selection
   task automatic pick_note(input logic [W-1:0] n);
      hold(n, DB + 2);
      hold('0, DB + 2);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(2);
      checks++;
      if ({busy, ram_rw, ram_addr, ram_data, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%b want=0", {busy, ram_rw, ram_addr, ram_data, done, err});
      end
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic test_basic();
      begin_txn();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", busy); end
      pick_note(7'b0000100);
      keys = 7'b0100000;
      cyc(DB);
      checks++;
      if (ram_rw !== 1'b0) begin errors++; $display("FAIL basic_latch_cycle ram_rw=%b want=0", ram_rw); end
      cyc(1);
      checks++;
      if ({ram_rw, ram_addr, ram_data} !== {1'b1, 7'b0000100, 7'b0100000}) begin
         errors++;
         $display("FAIL basic_write rw=%b addr=%b data=%b want 1/0000100/0100000", ram_rw, ram_addr, ram_data);
      end
      cyc(1);
      checks++;
      if ({ram_rw, ram_addr, ram_data, done} !== {1'b0, 14'b0, 1'b1}) begin
         errors++;
         $display("FAIL basic_done rw=%b addr=%b data=%b done=%b want 0/0/0/1", ram_rw, ram_addr, ram_data, done);
      end
      cyc(1);
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL basic_idle done=%b busy=%b want 0/0", done, busy); end
      hold('0, DB + 2);
   endtask

   task automatic test_multi();
      int e0;
      e0 = n_err;
      begin_txn();
      keys = 7'b0000011;
      cyc(DB);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL multi_err got=%b want=1", err); end
      cyc(1);
      checks++;
      if ({err, busy} !== 2'b01) begin errors++; $display("FAIL multi_hold err=%b busy=%b want 0/1", err, busy); end
      hold('0, DB + 2);
      pick_note(7'b0001000);
      hold(7'b1000000, DB + 1);
      checks++;
      if ({ram_rw, ram_addr, ram_data} !== {1'b1, 7'b0001000, 7'b1000000}) begin
         errors++;
         $display("FAIL multi_write rw=%b addr=%b data=%b want 1/0001000/1000000", ram_rw, ram_addr, ram_data);
      end
      cyc(2);
      checks++;
      if (n_err - e0 !== 1) begin errors++; $display("FAIL multi_err_count got=%0d want=1", n_err - e0); end
      hold('0, DB + 2);
   endtask

   task automatic test_bounce();
      int w0;
      begin_txn();
      pick_note(7'b0001000);
      w0 = n_wr;
      repeat (3) begin
         hold(7'b0000001, DB - 1);
         hold('0, 1);
      end
      hold('0, DB);
      checks++;
      if (n_wr !== w0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bounce_rejected writes=%0d busy=%b want %0d/1", n_wr, busy, w0);
      end
      hold(7'b0000001, DB + 1);
      checks++;
      if ({ram_rw, ram_addr, ram_data} !== {1'b1, 7'b0001000, 7'b0000001}) begin
         errors++;
         $display("FAIL bounce_accept rw=%b addr=%b data=%b want 1/0001000/0000001", ram_rw, ram_addr, ram_data);
      end
      cyc(2);
      hold('0, DB + 2);
   endtask

   task automatic test_cancel();
      int w0, d0;
      w0 = n_wr;
      d0 = n_done;
      begin_txn();
      pick_note(7'b0000010);
      cancel = 1'b1;
      cyc(1);
      cancel = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL cancel_selkey busy=%b want=0", busy); end
      begin_txn();
      pick_note(7'b0000010);
      hold(7'b0010000, DB + 1);
      checks++;
      if (ram_rw !== 1'b1) begin errors++; $display("FAIL cancel_reach_write ram_rw=%b want=1", ram_rw); end
      cancel = 1'b1;
      #1;
      checks++;
      if (ram_rw !== 1'b0) begin errors++; $display("FAIL cancel_write_suppress ram_rw=%b want=0", ram_rw); end
      cyc(1);
      cancel = 1'b0;
      checks++;
      if ({busy, done} !== 2'b00) begin errors++; $display("FAIL cancel_write_idle busy=%b done=%b want 0/0", busy, done); end
      cyc(2);
      checks++;
      if (n_wr !== w0 || n_done !== d0) begin
         errors++;
         $display("FAIL cancel_no_write writes=%0d dones=%0d want %0d/%0d", n_wr, n_done, w0, d0);
      end
      hold('0, DB + 2);
   endtask

   task automatic test_reset_mid();
      begin_txn();
      hold(7'b0000100, DB + 2);
      rst = 1'b1;
      cyc(1);
      checks++;
      if ({busy, ram_rw, ram_addr, ram_data, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs got=%b want=0", {busy, ram_rw, ram_addr, ram_data, done, err});
      end
      rst = 1'b0;
      hold('0, DB + 2);
      begin_txn();
      pick_note(7'b1000000);
      hold(7'b0000001, DB + 1);
      checks++;
      if ({ram_rw, ram_addr, ram_data} !== {1'b1, 7'b1000000, 7'b0000001}) begin
         errors++;
         $display("FAIL reset_mid_recover rw=%b addr=%b data=%b want 1/1000000/0000001", ram_rw, ram_addr, ram_data);
      end
      cyc(2);
      hold('0, DB + 2);
   endtask

   task automatic test_random();
      int base;
      base = wr_addr.size();
      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] n, k;
         int t;
         n = W'(1) << $urandom_range(0, W - 1);
         k = W'(1) << $urandom_range(0, W - 1);
         exp_addr.push_back(n);
         exp_data.push_back(k);
         cyc($urandom_range(0, 5));
         begin_txn();
         hold(n, DB + 1 + $urandom_range(0, 4));
         hold('0, DB + 1 + $urandom_range(0, 4));
         keys = k;
         t = 0;
         while (ram_rw !== 1'b1 && t < 20) begin
            cyc(1);
            t++;
         end
         checks++;
         if (t !== DB + 1 || ram_addr !== n || ram_data !== k) begin
            errors++;
            $display("FAIL random_write[%0d] latency=%0d addr=%b data=%b want %0d/%b/%b", i, t, ram_addr, ram_data, DB + 1, n, k);
         end
         cyc(1);
         checks++;
         if (done !== 1'b1) begin errors++; $display("FAIL random_done[%0d] got=%b want=1", i, done); end
         cyc(1);
         hold('0, DB + 2);
      end
      checks++;
      if (wr_addr.size() - base !== exp_addr.size()) begin
         errors++;
         $display("FAIL random_write_count got=%0d want=%0d", wr_addr.size() - base, exp_addr.size());
      end else begin
         foreach (exp_addr[j]) begin
            checks++;
            if (wr_addr[base + j] !== exp_addr[j] || wr_data[base + j] !== exp_data[j]) begin
               errors++;
               $display("FAIL random_log[%0d] addr=%b data=%b want %b/%b", j, wr_addr[base + j], wr_data[base + j], exp_addr[j], exp_data[j]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      int e0;
      e0 = n_err;
      begin_txn();
`ifdef REMAP_TIMEOUT_EN
      begin
         int t;
         t = 0;
         while (err !== 1'b1 && t < TO + 50) begin
            cyc(1);
            t++;
         end
         checks++;
         if (err !== 1'b1 || t !== TO - 1) begin
            errors++;
            $display("FAIL timeout_err err=%b cycles=%0d want 1/%0d", err, t, TO - 1);
         end
         cyc(1);
         checks++;
         if ({busy, err} !== 2'b00) begin errors++; $display("FAIL timeout_idle busy=%b err=%b want 0/0", busy, err); end
      end
`else
      cyc(1000);
      checks++;
      if (busy !== 1'b1 || n_err !== e0) begin
         errors++;
         $display("FAIL no_timeout busy=%b errs=%0d want 1/%0d", busy, n_err, e0);
      end
      cancel = 1'b1;
      cyc(1);
      cancel = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL no_timeout_cancel busy=%b want=0", busy); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi();
      test_bounce();
      test_cancel();
      test_reset_mid();
      test_random();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
